uart_rx_byte: RTL and testbench

//   UART receive front end: samples the asynchronous RX pin, recovers 8N1 frames (LSB first)
//   and presents each byte on a valid/ready interface to the command/mirror logic in top.

---
 rtl/uart_rx_byte.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchronised RX line, 8N1 frame recovery (LSB first),
// valid/ready output with framing-error and overrun pulses. Define UART_RX_PARITY_EN for 8E1.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  // state   | meaning
  // IDLE    | line idle, waiting for a low synced rx
  // START   | counting to mid start bit to reject glitches
  // DATA    | sampling 8 data bits at mid-bit, LSB first
  // PARITY  | sampling the even-parity bit (UART_RX_PARITY_EN only)
  // STOP    | sampling the stop bit; delivers or flags the byte
  // BREAK   | stop bit was low; wait for the line to return high
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s1_q, rx_s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             cnt_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    if (valid_q && rx_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s2_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_STOP;
          if (rx_s2_q != ^shift_q) begin
            perr_d    = 1'b1;
            par_bad_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (!par_bad_q) begin
`else
            begin
`endif
              // a held byte is only replaced if it is being accepted on this edge
              if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s2_q) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != S_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; parity scenario runs when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + HALF + 9 * CPB + (PAR_EN ? CPB : 0);

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

  int n_checks = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .resetn(resetn), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (overrun) ovr_cnt++;
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(CPB);
  endtask

  // leaves rx at the stop-bit level
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic clear_mon();
    ovr_cnt = 0;
    fe_cnt  = 0;
    pe_cnt  = 0;
    got_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 00", rx_data); end
    n_checks++;
    if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_busy: got %b%b expected 00", rx_valid, rx_busy);
    end
    n_checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(CPB);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_single();
    int n;
    bit found;
    clear_mon();
    rx_ready = 1'b1;
    n = 0; found = 1'b0;
    fork
      send_frame(8'h31, 1'b1, ^8'h31);
      begin
        while (n < 400 && !found) begin
          @(posedge clk); #1;
          n++;
          if (rx_valid) found = 1'b1;
        end
      end
    join
    idle(2 * CPB);
    n_checks++;
    if (!found || (n - 1) != LAT) begin
      n_fail++; $display("FAIL single_latency: got %0d (found=%0b) expected %0d", n - 1, found, LAT);
    end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h31) begin
      n_fail++; $display("FAIL single_data: got %0d bytes first %0h expected 1 byte 31", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    n_checks++;
    if (fe_cnt != 0 || rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got fe=%0d valid=%b expected fe=0 valid=0", fe_cnt, rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [5];
    msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h35;
    clear_mon();
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1, ^msg[i]);
    idle(2 * CPB);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h31) begin
      n_fail++; $display("FAIL b2b_held: got valid=%b data=%0h expected valid=1 data=31", rx_valid, rx_data);
    end
    n_checks++;
    if (ovr_cnt != 4) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 4", ovr_cnt); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rx_valid !== 1'b0 || got_q.size() != 1 || got_q[0] !== 8'h31) begin
      n_fail++; $display("FAIL b2b_accept: got valid=%b n=%0d expected valid=0 n=1 byte 31",
                         rx_valid, got_q.size());
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_ready = 1'b1;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b expected 1", rx_busy); end
    idle(6);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b expected 0", rx_busy); end
    idle(2 * CPB);
    n_checks++;
    if (got_q.size() != 0 || fe_cnt != 0) begin
      n_fail++; $display("FAIL glitch_output: got n=%0d fe=%0d expected 0 0", got_q.size(), fe_cnt);
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, ^8'hA5);
    rx = 1'b0;
    idle(20);
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b expected 1", rx_busy); end
    idle(20);
    rx = 1'b1;
    idle(CPB);
    n_checks++;
    if (rx_busy !== 1'b0 || fe_cnt != 1 || got_q.size() != 0) begin
      n_fail++; $display("FAIL frame_err: got busy=%b fe=%0d n=%0d expected 0 1 0", rx_busy, fe_cnt, got_q.size());
    end
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(2 * CPB);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A || fe_cnt != 1) begin
      n_fail++; $display("FAIL after_break: got n=%0d fe=%0d expected 1 byte 5a fe=1", got_q.size(), fe_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h33;
    clear_mon();
    rx_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    idle(HALF);
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b expected 1", rx_busy); end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_busy !== 1'b0 ||
        {frame_err, overrun, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL midframe_reset: got data=%0h v=%b b=%b p=%b expected all 0",
                         rx_data, rx_valid, rx_busy, {frame_err, overrun, parity_err});
    end
    @(posedge clk); #1;
    rx = 1'b1;
    resetn = 1'b1;
    idle(2 * CPB);
    send_frame(8'h34, 1'b1, ^8'h34);
    idle(2 * CPB);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h34 || fe_cnt != 0) begin
      n_fail++; $display("FAIL post_reset_frame: got n=%0d fe=%0d expected 1 byte 34 fe=0", got_q.size(), fe_cnt);
    end
  endtask

  task automatic test_parity();
    clear_mon();
    rx_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h07 || pe_cnt != 0) begin
      n_fail++; $display("FAIL parity_good: got n=%0d pe=%0d expected 1 byte 07 pe=0", got_q.size(), pe_cnt);
    end
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    n_checks++;
    if (got_q.size() != 1 || pe_cnt != 1 || fe_cnt != 0) begin
      n_fail++; $display("FAIL parity_bad: got n=%0d pe=%0d fe=%0d expected 1 1 0", got_q.size(), pe_cnt, fe_cnt);
    end
`else
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h07 || pe_cnt != 0) begin
      n_fail++; $display("FAIL no_parity: got n=%0d pe=%0d expected 1 byte 07 pe=0", got_q.size(), pe_cnt);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
